tmds_encoder: RTL and testbench
===============================

TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 Parameters: none; the encoding is fixed to DVI 1.0 TMDS 8b/10b.
REQ-002 clk  input  1  pixel clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 data  input  8  pixel colour byte for this channel; sampled when blank=0.
REQ-005 c0  input  1  control bit 0 (hsync on blue channel, 0 elsewhere).
REQ-006 c1  input  1  control bit 1 (vsync on blue channel, 0 elsewhere).
REQ-007 blank  input  1  1 = send control symbol, 0 = send encoded data.
REQ-008 encoded  output  10  TMDS symbol, LSB transmitted first, registered.

Function
REQ-009 The block SHALL be a 2-stage pipeline: inputs sampled at edge N, the corresponding symbol on encoded after edge N+2. It is free-running, with no stall or handshake.
REQ-010 Stage 1 SHALL register blank, c1, c0, q_m[8:0], and the 4-bit ones count of q_m[7:0] (n1q); n0q = 8 - n1q.
REQ-011 q_m SHALL be formed as follows, where n1 = ones in data:
- If n1>4, or (n1==4 and data[0]==0): XNOR mode, q_m[i] = ~(q_m[i-1]^data[i]), q_m[8]=0.
- Else: XOR mode, q_m[i] = q_m[i-1]^data[i], q_m[8]=1.
- In both modes q_m[0] = data[0].
REQ-012 Stage 2 SHALL hold running disparity cnt as a 5-bit two's-complement register; all cnt arithmetic SHALL be signed 5-bit.
REQ-013 Balanced branch: if cnt==0 or n1q==n0q, encoded = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
- cnt += (n1q-n0q) when q_m[8]=1.
- cnt += (n0q-n1q) when q_m[8]=0.
REQ-014 Invert branch: else if (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q), encoded = {1, q_m[8], ~q_m[7:0]}; cnt = cnt + 2*q_m[8] + (n0q-n1q).
REQ-015 Non-invert branch: otherwise encoded = {0, q_m[8], q_m[7:0]}; cnt = cnt - 2*(~q_m[8]) + (n1q-n0q).
REQ-016 When stage-1 blank=1, encoded SHALL be the control symbol for {c1,c0}:
- 00 -> 1101010100
- 01 -> 0010101011
- 10 -> 0101010100
- 11 -> 1010101011
In all four cases cnt SHALL be cleared to 0 on the same edge.
REQ-017 The blank-to-data transition SHALL start data encoding from cnt=0 with no gap symbol. The data-to-blank transition SHALL emit control symbols from the first blanked pixel.
REQ-018 cnt SHALL stay within -10..+10 for any input stream; no saturation logic is used.
REQ-019 Changes on c0/c1 while blank=0 SHALL have no effect on encoded.

Reset
REQ-020 While reset=1, the following SHALL hold asynchronously, independent of clk:
- encoded = 10'b1101010100
- cnt = 0
- stage-1 blank = 1, {c1,c0} = 00, q_m = 0, n1q = 0
REQ-021 On reset deassertion mid-stream, the first two output symbols SHALL be 1101010100, then pipeline data in order. No residual disparity is carried over.

Verification
REQ-022 Reset pulse asserted between clock edges during active data -> encoded = 1101010100 before the next edge; cnt = 0.
REQ-023 blank=1, {c1,c0}=01 held -> encoded = 0010101011 from the second edge after application; cnt remains 0.
REQ-024 cnt=0, data=8'h00 (blank=0) for two pixels:
- first symbol 0100000000, cnt=-8
- second symbol 1111111111, cnt=+2
REQ-025 cnt=0, data=8'hFF -> encoded = 1000000000, cnt=-8; then blank=1, {c1,c0}=10 -> 0101010100, cnt=0.
REQ-026 Drive 10000 random data/blank/c pixels and compare every symbol against a bit-accurate software model, including these checks:
- cnt stays within -10..+10
- decoding each data symbol recovers the original data byte
- latency is exactly 2 cycles

Source files
------------

// File: rtl/tmds_encoder.sv
// tmds_encoder: DVI 1.0 TMDS 8b/10b encoder for one colour channel.
// Two-stage, free-running pipeline: a byte or control pair sampled at edge N
// appears as a 10-bit symbol on `encoded` after edge N+2.
//
// Ports:
//   clk      pixel clock, all state updates on the rising edge
//   reset    asynchronous active-high reset, clears all state
//   data     pixel byte, used when blank = 0
//   c0, c1   control bits (hsync/vsync on blue), used when blank = 1
//   blank    1 = emit control symbol, 0 = emit encoded data
//   encoded  registered TMDS symbol, LSB transmitted first
module tmds_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       c0,
  input  logic       c1,
  input  logic       blank,
  output logic [9:0] encoded
);

  // Stage 1: transition minimisation
  logic [3:0] n1_d;
  logic [8:0] qm_d;
  logic [3:0] n1q_d;

  logic       blank_q;
  logic       c1_q;
  logic       c0_q;
  logic [8:0] qm_q;
  logic [3:0] n1q_q;

  always_comb begin
    logic       xnor_mode;
    logic [8:0] q;
    n1_d = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n1_d = n1_d + 4'(data[i]);
    end
    xnor_mode = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
    q    = '0;
    q[0] = data[0];
    for (int unsigned i = 1; i < 8; i++) begin
      q[i] = xnor_mode ? ~(q[i-1] ^ data[i]) : (q[i-1] ^ data[i]);
    end
    q[8] = ~xnor_mode;
    qm_d = q;
    n1q_d = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n1q_d = n1q_d + 4'(q[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_q <= 1'b1;
      c1_q    <= 1'b0;
      c0_q    <= 1'b0;
      qm_q    <= '0;
      n1q_q   <= '0;
    end else begin
      blank_q <= blank;
      c1_q    <= c1;
      c0_q    <= c0;
      qm_q    <= qm_d;
      n1q_q   <= n1q_d;
    end
  end

  // Stage 2: DC balancing with a 5-bit signed running disparity
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_d;
  logic signed [4:0] diff;
  logic        [9:0] sym_d;
  logic              qm8;

  always_comb begin
    qm8   = qm_q[8];
    // n1q - n0q == 2*n1q - 8, range -8..+8
    diff  = $signed({n1q_q, 1'b0}) - 5'sd8;
    sym_d = '0;
    cnt_d = cnt;
    if (blank_q) begin
      case ({c1_q, c0_q})
        2'b00:   sym_d = 10'b1101010100;
        2'b01:   sym_d = 10'b0010101011;
        2'b10:   sym_d = 10'b0101010100;
        default: sym_d = 10'b1010101011;
      endcase
      cnt_d = '0;
    end else if ((cnt == 5'sd0) || (n1q_q == 4'd4)) begin
      sym_d = {~qm8, qm8, (qm8 ? qm_q[7:0] : ~qm_q[7:0])};
      cnt_d = qm8 ? (cnt + diff) : (cnt - diff);
    end else if ((!cnt[4] && (n1q_q > 4'd4)) || (cnt[4] && (n1q_q < 4'd4))) begin
      // cnt is non-zero here, so the sign bit alone separates >0 from <0
      sym_d = {1'b1, qm8, ~qm_q[7:0]};
      cnt_d = cnt + (qm8 ? 5'sd2 : 5'sd0) - diff;
    end else begin
      sym_d = {1'b0, qm8, qm_q[7:0]};
      cnt_d = cnt - (qm8 ? 5'sd0 : 5'sd2) + diff;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      encoded <= 10'b1101010100;
      cnt     <= '0;
    end else begin
      encoded <= sym_d;
      cnt     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
module tb_tmds_encoder;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       c0;
  logic       c1;
  logic       blank;
  logic [9:0] encoded;

  int passed;
  int total;

  tmds_encoder dut (
    .clk     (clk),
    .reset   (reset),
    .data    (data),
    .c0      (c0),
    .c1      (c1),
    .blank   (blank),
    .encoded (encoded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [7:0] d, input logic b, input logic h1, input logic h0);
    data  = d;
    blank = b;
    c1    = h1;
    c0    = h0;
  endtask

  function automatic int dut_cnt();
    return int'($signed(dut.cnt));
  endfunction

  task automatic test_reset();
    // mid-stream data, then an asynchronous pulse between edges
    apply(8'hA7, 1'b0, 1'b0, 1'b0);
    step(); step(); step();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (encoded !== 10'b1101010100) $display("FAIL reset_async_sym got %b exp %b", encoded, 10'b1101010100);
    else passed++;
    total++;
    if (dut_cnt() !== 0) $display("FAIL reset_async_cnt got %0d exp 0", dut_cnt());
    else passed++;
    step();
    reset = 1'b0;
    apply(8'h00, 1'b0, 1'b0, 1'b0);
    step();
    total++;
    if (encoded !== 10'b1101010100) $display("FAIL reset_release_sym got %b exp %b", encoded, 10'b1101010100);
    else passed++;
    step();
    total++;
    if (encoded !== 10'b0100000000) $display("FAIL reset_first_data got %b exp %b", encoded, 10'b0100000000);
    else passed++;
  endtask

  task automatic test_control();
    logic [9:0] exp_sym [4];
    exp_sym[0] = 10'b1101010100;
    exp_sym[1] = 10'b0010101011;
    exp_sym[2] = 10'b0101010100;
    exp_sym[3] = 10'b1010101011;
    for (int i = 0; i < 4; i++) begin
      apply(8'h3C, 1'b1, i[1], i[0]);
      step(); step();
      total++;
      if (encoded !== exp_sym[i]) $display("FAIL ctrl_sym%0d got %b exp %b", i, encoded, exp_sym[i]);
      else passed++;
      total++;
      if (dut_cnt() !== 0) $display("FAIL ctrl_cnt%0d got %0d exp 0", i, dut_cnt());
      else passed++;
    end
  endtask

  task automatic test_zero_pair();
    apply(8'h00, 1'b1, 1'b0, 1'b0);
    step(); step();
    apply(8'h00, 1'b0, 1'b0, 1'b0);
    step(); step();
    total++;
    if (encoded !== 10'b0100000000) $display("FAIL zero_first_sym got %b exp %b", encoded, 10'b0100000000);
    else passed++;
    total++;
    if (dut_cnt() !== -8) $display("FAIL zero_first_cnt got %0d exp -8", dut_cnt());
    else passed++;
    step();
    total++;
    if (encoded !== 10'b1111111111) $display("FAIL zero_second_sym got %b exp %b", encoded, 10'b1111111111);
    else passed++;
    total++;
    if (dut_cnt() !== 2) $display("FAIL zero_second_cnt got %0d exp 2", dut_cnt());
    else passed++;
  endtask

  task automatic test_ff_then_blank();
    apply(8'h00, 1'b1, 1'b0, 1'b0);
    step(); step();
    apply(8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    apply(8'hFF, 1'b1, 1'b1, 1'b0);
    step();
    total++;
    if (encoded !== 10'b1000000000) $display("FAIL ff_sym got %b exp %b", encoded, 10'b1000000000);
    else passed++;
    total++;
    if (dut_cnt() !== -8) $display("FAIL ff_cnt got %0d exp -8", dut_cnt());
    else passed++;
    step();
    total++;
    if (encoded !== 10'b0101010100) $display("FAIL ff_blank_sym got %b exp %b", encoded, 10'b0101010100);
    else passed++;
    total++;
    if (dut_cnt() !== 0) $display("FAIL ff_blank_cnt got %0d exp 0", dut_cnt());
    else passed++;
  endtask

  // 0x55 is balanced in XOR mode: q_m = 1_00110011, so cnt stays 0
  task automatic test_control_ignored();
    apply(8'h00, 1'b1, 1'b0, 1'b0);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      apply(8'h55, 1'b0, i[1], i[0]);
      step();
      if (i > 0) begin
        total++;
        if (encoded !== 10'b0100110011) $display("FAIL cignore%0d got %b exp %b", i, encoded, 10'b0100110011);
        else passed++;
      end
    end
    step();
    total++;
    if (encoded !== 10'b0100110011) $display("FAIL cignore_last got %b exp %b", encoded, 10'b0100110011);
    else passed++;
  endtask

  // Reference encoder with integer disparity
  task automatic model(input logic [7:0] d, input logic b, input logic h1, input logic h0,
                       inout int mcnt, output logic [9:0] sym);
    int n1, ones, zeros;
    logic xm, q8, t;
    logic [7:0] qm;
    if (b) begin
      case ({h1, h0})
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
      mcnt = 0;
      return;
    end
    n1 = $countones(d);
    xm = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      t = qm[i-1] ^ d[i];
      qm[i] = xm ? ~t : t;
    end
    q8 = ~xm;
    ones = $countones(qm);
    zeros = 8 - ones;
    if (mcnt == 0 || ones == zeros) begin
      sym = {~q8, q8, (q8 ? qm : ~qm)};
      mcnt = mcnt + (q8 ? (ones - zeros) : (zeros - ones));
    end else if ((mcnt > 0 && ones > zeros) || (mcnt < 0 && zeros > ones)) begin
      sym = {1'b1, q8, ~qm};
      mcnt = mcnt + (q8 ? 2 : 0) + zeros - ones;
    end else begin
      sym = {1'b0, q8, qm};
      mcnt = mcnt - (q8 ? 0 : 2) + ones - zeros;
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] x, o;
    x = s[9] ? ~s[7:0] : s[7:0];
    o[0] = x[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
    return o;
  endfunction

  task automatic test_random();
    localparam int N = 10000;
    logic [7:0] pd [N];
    logic       pb [N];
    logic [9:0] psym [N];
    int         pcnt [N];
    int         mcnt;
    int         nfail;
    logic [9:0] s;
    apply(8'h00, 1'b1, 1'b0, 1'b0);
    step(); step();
    mcnt = 0;
    nfail = 0;
    for (int k = 0; k <= N; k++) begin
      if (k < N) begin
        pd[k] = 8'($urandom);
        pb[k] = ($urandom_range(0, 7) == 0);
        apply(pd[k], pb[k], 1'($urandom), 1'($urandom));
        model(pd[k], pb[k], c1, c0, mcnt, s);
        psym[k] = s;
        pcnt[k] = mcnt;
      end else begin
        apply(8'h00, 1'b1, 1'b0, 1'b0);
      end
      step();
      if (k >= 1) begin
        total++;
        if (encoded !== psym[k-1]) begin
          if (nfail < 10) $display("FAIL rand_sym px%0d got %b exp %b", k-1, encoded, psym[k-1]);
          nfail++;
        end else passed++;
        total++;
        if (dut_cnt() !== pcnt[k-1]) begin
          if (nfail < 10) $display("FAIL rand_cnt px%0d got %0d exp %0d", k-1, dut_cnt(), pcnt[k-1]);
          nfail++;
        end else passed++;
        total++;
        if (dut_cnt() < -10 || dut_cnt() > 10) begin
          if (nfail < 10) $display("FAIL rand_cnt_range px%0d got %0d exp -10..10", k-1, dut_cnt());
          nfail++;
        end else passed++;
        if (!pb[k-1]) begin
          total++;
          if (decode(encoded) !== pd[k-1]) begin
            if (nfail < 10) $display("FAIL rand_decode px%0d got %h exp %h", k-1, decode(encoded), pd[k-1]);
            nfail++;
          end else passed++;
        end
      end
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    apply(8'h00, 1'b1, 1'b0, 1'b0);
    #1;
    total++;
    if (encoded !== 10'b1101010100) $display("FAIL reset_init got %b exp %b", encoded, 10'b1101010100);
    else passed++;
    step(); step();
    reset = 1'b0;
    step();
    test_reset();
    test_control();
    test_zero_pair();
    test_ff_then_blank();
    test_control_ignored();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
